// File: rtl/tri_unpack.sv
// tri_unpack -- assembles six packed 32-bit words into one triangle.
//
// Each triangle arrives as six words. Words 0..4 are held in an assembly
// buffer. Word 5 loads the output register together with the buffer.
// Because of this double buffering, the next triangle can start
// arriving while the current one waits for the bisect stage.
//
// Ports
//   clk         rising-edge clock
//   n_rst       asynchronous reset, active-high (1 = reset)
//   clear       synchronous flush, active-high, takes priority over traffic
//   word_in     packed triangle word
//   word_valid  word_in is valid
//   word_ready  word is accepted this cycle (registered state only)
//   tri_out     assembled vertices p, q, r (16-bit x, y, z each)
//   color_r/g/b triangle colour
//   tri_valid   tri_out / colour valid for the bisect stage
//   tri_ready   bisect stage consumes the triangle this cycle
//   tri_count   delivered triangles, modulo 2^CNT_W

package tri_unpack_pkg;
   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
   } vertex_t;

   typedef struct packed {
      vertex_t p;
      vertex_t q;
      vertex_t r;
   } Triangle3D;
endpackage

module tri_unpack
   import tri_unpack_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic [31:0]      word_in,
   input  logic             word_valid,
   output logic             word_ready,
   output Triangle3D        tri_out,
   output logic [7:0]       color_r,
   output logic [7:0]       color_g,
   output logic [7:0]       color_b,
   output logic             tri_valid,
   input  logic             tri_ready,
   output logic [CNT_W-1:0] tri_count
);

   localparam logic [2:0] LAST_IDX = 3'd5;

   logic [2:0]  word_idx;
   logic [31:0] asm_buf [0:4];
   logic        accept;
   logic        consume;

   // Word 5 cannot be taken while the output register is still occupied.
   // Since this is the only stall, a load and a consume never share an edge.
   always_comb begin
      word_ready = !clear && !((word_idx == LAST_IDX) && tri_valid);
      accept     = word_valid && word_ready;
      consume    = tri_valid && tri_ready;
   end

   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         word_idx  <= '0;
         tri_valid <= 1'b0;
         tri_count <= '0;
         for (int unsigned i = 0; i < 5; i++) begin
            asm_buf[i] <= '0;
         end
         tri_out   <= '0;
         color_r   <= '0;
         color_g   <= '0;
         color_b   <= '0;
      end else if (clear) begin
         word_idx  <= '0;
         tri_valid <= 1'b0;
         tri_count <= '0;
      end else begin
         if (consume) begin
            tri_valid <= 1'b0;
            tri_count <= tri_count + CNT_W'(1);
         end
         if (accept) begin
            if (word_idx == LAST_IDX) begin
               word_idx    <= '0;
               tri_valid   <= 1'b1;
               tri_out.p.x <= asm_buf[0][15:0];
               tri_out.p.y <= asm_buf[0][31:16];
               tri_out.p.z <= asm_buf[1][15:0];
               tri_out.q.x <= asm_buf[1][31:16];
               tri_out.q.y <= asm_buf[2][15:0];
               tri_out.q.z <= asm_buf[2][31:16];
               tri_out.r.x <= asm_buf[3][15:0];
               tri_out.r.y <= asm_buf[3][31:16];
               tri_out.r.z <= asm_buf[4][15:0];
               color_r     <= asm_buf[4][23:16];
               color_g     <= asm_buf[4][31:24];
               color_b     <= word_in[7:0];
            end else begin
               asm_buf[word_idx] <= word_in;
               word_idx          <= word_idx + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tri_unpack.sv
// Randomised and directed bench for tri_unpack (CNT_W reduced to 4).
// The reference model follows the triangle packing rules directly. It
// keeps the words of the current triangle in an array and builds the
// expected fields with division and modulo.

module tb_tri_unpack;
   import tri_unpack_pkg::*;

   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          n_rst;
   logic          clear;
   logic [31:0]   word_in;
   logic          word_valid;
   logic          word_ready;
   Triangle3D     tri_out;
   logic [7:0]    color_r;
   logic [7:0]    color_g;
   logic [7:0]    color_b;
   logic          tri_valid;
   logic          tri_ready;
   logic [CW-1:0] tri_count;

   tri_unpack #(.CNT_W(CW)) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .clear      (clear),
      .word_in    (word_in),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .tri_out    (tri_out),
      .color_r    (color_r),
      .color_g    (color_g),
      .color_b    (color_b),
      .tri_valid  (tri_valid),
      .tri_ready  (tri_ready),
      .tri_count  (tri_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int          m_idx    = 0;
   bit          m_valid  = 1'b0;
   int          m_count  = 0;
   logic [31:0] m_words [6];
   logic [15:0] e_v [9];      // p.x p.y p.z q.x q.y q.z r.x r.y r.z
   logic [7:0]  e_r, e_g, e_b;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_build();
      for (int k = 0; k < 5; k++) begin
         e_v[2*k] = 16'(m_words[k] % 65536);
         if (k < 4) e_v[2*k+1] = 16'(m_words[k] / 65536);
      end
      e_r = 8'((m_words[4] / 65536) % 256);
      e_g = 8'(m_words[4] / 16777216);
      e_b = 8'(m_words[5] % 256);
   endfunction

   function automatic void model_reset();
      m_idx   = 0;
      m_valid = 1'b0;
      m_count = 0;
   endfunction

   // One clock cycle: drive at posedge+1, compare at negedge, advance the model at posedge.
   task automatic cycle(input logic v, input logic [31:0] w, input logic rdy,
                        input logic clr, output logic acc);
      logic m_ready;
      word_valid = v;
      word_in    = w;
      tri_ready  = rdy;
      clear      = clr;
      m_ready = !clr && !(m_idx == 5 && m_valid);
      acc     = v && m_ready;
      @(negedge clk);
      check("word_ready", 64'(word_ready), 64'(m_ready));
      check("tri_valid", 64'(tri_valid), 64'(m_valid));
      check("tri_count", 64'(tri_count), 64'(m_count));
      if (m_valid) begin
         check("vertex_p", 64'({tri_out.p.x, tri_out.p.y, tri_out.p.z}), 64'({e_v[0], e_v[1], e_v[2]}));
         check("vertex_q", 64'({tri_out.q.x, tri_out.q.y, tri_out.q.z}), 64'({e_v[3], e_v[4], e_v[5]}));
         check("vertex_r", 64'({tri_out.r.x, tri_out.r.y, tri_out.r.z}), 64'({e_v[6], e_v[7], e_v[8]}));
         check("colour", 64'({color_r, color_g, color_b}), 64'({e_r, e_g, e_b}));
      end
      @(posedge clk);
      if (clr) begin
         model_reset();
      end else begin
         if (m_valid && rdy) begin
            m_valid = 1'b0;
            m_count = (m_count + 1) % 16;
         end
         if (acc) begin
            m_words[m_idx] = w;
            if (m_idx == 5) begin
               model_build();
               m_valid = 1'b1;
               m_idx   = 0;
            end else begin
               m_idx++;
            end
         end
      end
      #1;
   endtask

   task automatic send_word(input logic [31:0] w, input logic rdy);
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) cycle(1'b1, w, rdy, 1'b0, acc);
      check("send_timeout", 64'(acc), 64'd1);
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) cycle(1'b0, $urandom, 1'b1, 1'b0, acc);
   endtask

   logic        acc;
   logic [31:0] dir_w [6];
   logic [31:0] bp_w;

   initial begin
      n_rst      = 1'b1;
      clear      = 1'b0;
      word_valid = 1'b0;
      word_in    = '0;
      tri_ready  = 1'b0;
      #12;
      check("rst_valid", 64'(tri_valid), 64'd0);
      check("rst_count", 64'(tri_count), 64'd0);
      check("rst_tri_pq", 64'({tri_out.p, tri_out.q[15:0]}), 64'd0);
      check("rst_colour", 64'({color_r, color_g, color_b}), 64'd0);
      @(negedge clk);
      n_rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_ready", 64'(word_ready), 64'd1);

      // basic triangle with tri_ready held high
      dir_w[0] = 32'h0002_0001; dir_w[1] = 32'h0004_0003; dir_w[2] = 32'h0006_0005;
      dir_w[3] = 32'h0008_0007; dir_w[4] = 32'hBBAA_0009; dir_w[5] = 32'hFFFF_FFCC;
      for (int i = 0; i < 6; i++) send_word(dir_w[i], 1'b1);
      check("dir_valid", 64'(tri_valid), 64'd1);
      check("dir_p", 64'({tri_out.p.x, tri_out.p.y, tri_out.p.z}), 64'h0000_0001_0002_0003);
      check("dir_q", 64'({tri_out.q.x, tri_out.q.y, tri_out.q.z}), 64'h0000_0004_0005_0006);
      check("dir_r", 64'({tri_out.r.x, tri_out.r.y, tri_out.r.z}), 64'h0000_0007_0008_0009);
      check("dir_rgb", 64'({color_r, color_g, color_b}), 64'h00AA_BBCC);
      idle(1);
      check("dir_one_cycle", 64'(tri_valid), 64'd0);
      check("dir_count", 64'(tri_count), 64'd1);
      idle(2);

      // backpressure: 12 words with tri_ready low
      for (int i = 0; i < 11; i++) begin
         bp_w = 32'hA000_0000 | (32'(i) * 32'h0001_0001);
         send_word(bp_w, 1'b0);
      end
      bp_w = 32'hA00B_000B;
      for (int i = 0; i < 3; i++) cycle(1'b1, bp_w, 1'b0, 1'b0, acc);
      check("bp_ready_low", 64'(word_ready), 64'd0);
      check("bp_first_px", 64'(tri_out.p.x), 64'h0000);
      cycle(1'b1, bp_w, 1'b1, 1'b0, acc);
      check("bp_consumed", 64'(tri_valid), 64'd0);
      cycle(1'b1, bp_w, 1'b0, 1'b0, acc);
      check("bp_late_accept", 64'(acc), 64'd1);
      check("bp_tri2_valid", 64'(tri_valid), 64'd1);
      check("bp_tri2_p", 64'({tri_out.p.x, tri_out.p.y, tri_out.p.z}), 64'h0000_0006_A006_0007);
      check("bp_tri2_b", 64'(color_b), 64'h0B);
      for (int i = 0; i < 3; i++) cycle(1'b0, $urandom, 1'b0, 1'b0, acc);
      idle(2);

      // partial triangle flushed by clear
      for (int i = 0; i < 3; i++) send_word($urandom, 1'b1);
      cycle(1'b1, $urandom, 1'b1, 1'b1, acc);
      for (int i = 0; i < 6; i++) send_word($urandom, 1'b1);
      idle(2);
      check("clr_count", 64'(tri_count), 64'd1);

      // clear beats a concurrent consume
      for (int i = 0; i < 6; i++) send_word($urandom, 1'b0);
      check("clr_pre_valid", 64'(tri_valid), 64'd1);
      cycle(1'b0, $urandom, 1'b1, 1'b1, acc);
      check("clr_consume_count", 64'(tri_count), 64'd0);
      check("clr_consume_valid", 64'(tri_valid), 64'd0);

      // asynchronous reset mid-triangle with a triangle pending
      for (int i = 0; i < 10; i++) send_word($urandom, 1'b0);
      check("arst_pre_valid", 64'(tri_valid), 64'd1);
      word_valid = 1'b0;
      #2;
      n_rst = 1'b1;
      #1;
      check("arst_valid", 64'(tri_valid), 64'd0);
      check("arst_count", 64'(tri_count), 64'd0);
      check("arst_p", 64'(tri_out.p), 64'd0);
      check("arst_ready", 64'(word_ready), 64'd1);
      model_reset();
      @(posedge clk);
      #2;
      n_rst = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) send_word($urandom, 1'b1);
      idle(2);
      check("arst_after_count", 64'(tri_count), 64'd1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)),
               $urandom_range(0, 99) == 0, acc);
      end

      // 17 triangles with sparse word_valid: counter wraps to 1
      cycle(1'b0, $urandom, 1'b1, 1'b1, acc);
      for (int t = 0; t < 17; t++) begin
         for (int i = 0; i < 6; i++) begin
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) cycle(1'b0, $urandom, 1'b1, 1'b0, acc);
            send_word($urandom, 1'b1);
         end
      end
      idle(2);
      check("wrap_count", 64'(tri_count), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tri_unpack.md
TRI_UNPACK -- requirements
Module: tri_unpack

Interface
REQ-001 Parameter: CNT_W, default 16, width of the delivered-triangle counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-high (1 = reset asserted).
REQ-004 clear  input  1  synchronous soft flush, active-high.
REQ-005 word_in  input  32  packed triangle word from the AHB slave buffer.
REQ-006 word_valid  input  1  word_in holds a valid word.
REQ-007 word_ready  output  1  block accepts word_in this cycle.
REQ-008 tri_out  output  Triangle3D  assembled vertices p, q, r; each has 16-bit x, y, z.
REQ-009 color_r, color_g, color_b  output  8 each  triangle colour.
REQ-010 tri_valid  output  1  tri_out and colour are valid for the bisect stage.
REQ-011 tri_ready  input  1  bisect stage consumes the triangle this cycle.
REQ-012 tri_count  output  CNT_W  number of triangles delivered, modulo 2^CNT_W.

Function
REQ-013 The block SHALL transfer a word when word_valid && word_ready at a rising edge; a transfer with only one of the two signals high SHALL NOT occur.
REQ-014 Each triangle SHALL consist of 6 consecutive accepted words, indexed 0..5 by a word counter that resets to 0.
REQ-015 Packing SHALL be: w0 = {p.y, p.x}; w1 = {q.x, p.z}; w2 = {q.z, q.y}; w3 = {r.y, r.x}; w4 = {g, r, r.z}, i.e. [15:0] r.z, [23:16] colour r, [31:24] colour g; w5[7:0] = colour b, and w5[31:8] is ignored.
REQ-016 Words 0..4 SHALL be stored in an assembly buffer; the counter SHALL increment on each accepted word and wrap from 5 to 0.
REQ-017 On acceptance of word 5, the assembly buffer plus word 5 SHALL load the output register at that same edge, and tri_valid SHALL be 1 from the next cycle (latency: one edge after the last word).
REQ-018 word_ready SHALL be 0 when counter == 5 and tri_valid == 1, and SHALL be 0 while clear == 1; otherwise it SHALL be 1. word_ready SHALL NOT depend combinationally on tri_ready or word_valid.
REQ-019 While tri_valid == 1, words 0..4 of the next triangle SHALL still be accepted (double buffering).
REQ-020 tri_out, color_* and tri_valid SHALL hold stable while tri_valid && !tri_ready.
REQ-021 On tri_valid && tri_ready, tri_valid SHALL clear at that edge, and tri_count SHALL increment at that edge, wrapping from 2^CNT_W-1 to 0.
REQ-022 A new output load and a consume SHALL never coincide, because REQ-018 guarantees it; word 5 is then accepted no earlier than the cycle after the consume.
REQ-023 Fields SHALL be pure bit slices with no arithmetic, sign extension or reordering.
REQ-024 clear SHALL have priority over all other events at that edge: the counter, tri_valid and tri_count go to 0; a word presented that cycle is dropped; a concurrent consume does not increment tri_count; the data registers are don't-care.

Reset
REQ-025 While n_rst == 1, the following SHALL be forced to 0 immediately, independent of clk: the counter, tri_valid, tri_count, the assembly buffer, tri_out and color_*. word_ready SHALL be 1 after reset release with clear == 0.
REQ-026 Reset asserted mid-triangle SHALL discard the partial words; the first word accepted after release SHALL be treated as w0.

Verification
REQ-027 After reset, send 6 back-to-back words: w0 = 0x0002_0001, w1 = 0x0004_0003, w2 = 0x0006_0005, w3 = 0x0008_0007, w4 = 0xBBAA_0009, w5 = 0xFFFF_FFCC, with tri_ready = 1. Required: tri_valid high for exactly 1 cycle, starting 1 cycle after w5. Values: p = (1,2,3), q = (4,5,6), r = (7,8,9), colour r/g/b = 0xAA/0xBB/0xCC, tri_count = 1.
REQ-028 Backpressure: hold tri_ready = 0, stream 12 words. Required: words 6..10 accepted, word_ready = 0 while the 12th word is pending. Then set tri_ready = 1 for one cycle. Required: the first triangle is consumed, the 12th word is accepted in the following cycle, and the second triangle is presented unchanged.
REQ-029 Send 3 words, pulse clear, then send 6 new words. Required: only the new triangle is output, and tri_count = 1.
REQ-030 Assert n_rst after 4 words with tri_valid = 1. Required: tri_valid = 0 and tri_count = 0 with no clock edge needed; after release, the next 6 words form one correct triangle.
REQ-031 Deliver 2^CNT_W + 1 triangles, with a reduced CNT_W = 4 allowed. Required: tri_count wraps to 1; sparse word_valid gaps do not alter packing.
REQ-032 At an edge with clear = 1, tri_valid = 1 and tri_ready = 1: required tri_count = 0 and tri_valid = 0 after the edge.
